// File: rtl/decrypt_engine_if.sv
// Request/response bundle for decrypt_engine.
//   master: drives start, set_key, halt, state (ciphertext), key; observes results.
//   slave : the engine; returns out (plaintext), out_valid, busy, key_ready.
interface decrypt_engine_if;
  logic         start;
  logic         set_key;
  logic         halt;
  logic [127:0] state;
  logic [127:0] key;
  logic [127:0] out;
  logic         out_valid;
  logic         busy;
  logic         key_ready;

  modport master (
    output start, set_key, halt, state, key,
    input  out, out_valid, busy, key_ready
  );

  modport slave (
    input  start, set_key, halt, state, key,
    output out, out_valid, busy, key_ready
  );
endinterface

// File: rtl/decrypt_engine.sv
// Iterative AES-128 inverse cipher.
// A loaded cipher key is expanded forward once to get the last round key (K10).
// Each block then runs 10 round cycles, walking the key schedule backwards on the
// fly, so only K10 and the current round key are stored.
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   bus      : decrypt_engine_if.slave (start/set_key/halt/state/key in,
//              out/out_valid/busy/key_ready out, all outputs registered)
module decrypt_engine (
  input  logic             clk,
  input  logic             rst,
  decrypt_engine_if.slave  bus
);

  localparam int unsigned BLK_W = 128;
  localparam int unsigned RC_W  = 4;

  typedef enum logic [1:0] {ST_IDLE, ST_KEXP, ST_ROUND} st_e;

  // GF(2^8) helpers; S-boxes are computed as inversion plus affine map.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // a^254 == a^-1 (and 0 maps to 0).
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int i = 0; i < 7; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x;
    x = ginv(a);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^
           {x[3:0], x[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] y;
    y = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    return ginv(y);
  endfunction

  function automatic logic [7:0] rcon(input logic [RC_W-1:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // SubWord(RotWord(w)).
  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    logic [31:0] r;
    r = {w[23:0], w[31:24]};
    return {sbox(r[31:24]), sbox(r[23:16]), sbox(r[15:8]), sbox(r[7:0])};
  endfunction

  function automatic logic [BLK_W-1:0] key_fwd(input logic [BLK_W-1:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ sub_rot(k[31:0]) ^ {rc, 24'h0};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0]  ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Inverse key step: recovers K_i from K_(i+1).
  function automatic logic [BLK_W-1:0] key_inv(input logic [BLK_W-1:0] k, input logic [7:0] rc);
    logic [31:0] u0, u1, u2, u3;
    u3 = k[31:0]  ^ k[63:32];
    u2 = k[63:32] ^ k[95:64];
    u1 = k[95:64] ^ k[127:96];
    u0 = k[127:96] ^ sub_rot(u3) ^ {rc, 24'h0};
    return {u0, u1, u2, u3};
  endfunction

  // Byte n (FIPS order, column-major) lives at bits [127-8n -: 8].
  function automatic logic [BLK_W-1:0] inv_shift_sub(input logic [BLK_W-1:0] s);
    logic [BLK_W-1:0] o;
    int src;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = 4 * ((c - r + 4) % 4) + r;
        o[127 - 8 * (4 * c + r) -: 8] = inv_sbox(s[127 - 8 * src -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [BLK_W-1:0] inv_mix(input logic [BLK_W-1:0] s);
    logic [BLK_W-1:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32 * c -: 8];
      a1 = s[119 - 32 * c -: 8];
      a2 = s[111 - 32 * c -: 8];
      a3 = s[103 - 32 * c -: 8];
      o[127 - 32 * c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119 - 32 * c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111 - 32 * c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103 - 32 * c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

  st_e              st_q, st_d;
  logic [RC_W-1:0]  rc_q, rc_d;
  logic [BLK_W-1:0] key_q, key_d;   // expansion key in KEXP, current round key in ROUND
  logic [BLK_W-1:0] k10_q, k10_d;
  logic [BLK_W-1:0] s_q, s_d;
  logic [BLK_W-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             key_ready_q, key_ready_d;

  logic [BLK_W-1:0] fwd_key_c;
  logic [BLK_W-1:0] inv_key_c;
  logic [BLK_W-1:0] sub_c;

  // Shared round datapath terms.
  always_comb begin
    fwd_key_c = key_fwd(key_q, rcon(rc_q));
    inv_key_c = key_inv(key_q, rcon(RC_W'(rc_q + 4'd1)));
    sub_c     = inv_shift_sub(s_q);
  end

  // Next-state and output logic; priority halt > set_key > start.
  always_comb begin
    st_d        = st_q;
    rc_d        = rc_q;
    key_d       = key_q;
    k10_d       = k10_q;
    s_d         = s_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    key_ready_d = key_ready_q;

    case (st_q)
      ST_IDLE: begin
        if (bus.halt) begin
          st_d = ST_IDLE;
        end else if (bus.set_key) begin
          key_d       = bus.key;
          rc_d        = RC_W'(1);
          key_ready_d = 1'b0;
          st_d        = ST_KEXP;
        end else if (bus.start && key_ready_q) begin
          s_d   = bus.state ^ k10_q;
          key_d = k10_q;
          rc_d  = RC_W'(9);
          st_d  = ST_ROUND;
        end
      end
      ST_KEXP: begin
        if (bus.halt) begin
          key_ready_d = 1'b0;
          st_d        = ST_IDLE;
        end else begin
          key_d = fwd_key_c;
          rc_d  = RC_W'(rc_q + 4'd1);
          if (rc_q == RC_W'(10)) begin
            k10_d       = fwd_key_c;
            key_ready_d = 1'b1;
            st_d        = ST_IDLE;
          end
        end
      end
      ST_ROUND: begin
        if (bus.halt) begin
          st_d = ST_IDLE;
        end else begin
          key_d = inv_key_c;
          if (rc_q == '0) begin
            out_d       = sub_c ^ inv_key_c;
            out_valid_d = 1'b1;
            st_d        = ST_IDLE;
          end else begin
            s_d  = inv_mix(sub_c ^ inv_key_c);
            rc_d = RC_W'(rc_q - 4'd1);
          end
        end
      end
      default: st_d = ST_IDLE;
    endcase

    busy_d = (st_d != ST_IDLE);
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q        <= ST_IDLE;
      rc_q        <= '0;
      key_q       <= '0;
      k10_q       <= '0;
      s_q         <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      key_ready_q <= 1'b0;
    end else begin
      st_q        <= st_d;
      rc_q        <= rc_d;
      key_q       <= key_d;
      k10_q       <= k10_d;
      s_q         <= s_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      key_ready_q <= key_ready_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.key_ready = key_ready_q;

endmodule
